ov7670_config_seq: RTL and testbench
====================================

Name: ov7670_config_seq

Overview:
- Sequencer that walks the OV7670 register-init ROM from address 0 upward and issues each {register, value} pair as a write to the SCCB master.
- Sits between the init ROM (upstream) and the SCCB master (downstream).
- Interprets two ROM marker words:
  - 16'hFF_F0: timed delay, no write issued.
  - 16'hFF_FF: end of table.
- Reports busy, done and error to the capture/HDR control logic, which holds the camera pipeline until done.

Parameters:
- CLK_FREQ_HZ, 25000000, system clock frequency.
- DELAY_MS, 10, length of the FF_F0 delay in milliseconds. DELAY_CYCLES = CLK_FREQ_HZ/1000*DELAY_MS.
- MAX_RETRY, 3, number of consecutive NACKed attempts on one entry before aborting.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins or restarts the sequence.
- rom_addr  out  8  address to the init ROM.
- rom_data  in  16  ROM word: [15:8] register, [7:0] value. Registered ROM; valid 1 cycle after rom_addr changes.
- sccb_req  out  1  write request to the SCCB master.
- sccb_reg  out  8  register address for the write.
- sccb_val  out  8  data byte for the write.
- sccb_ready  in  1  master can accept a request.
- sccb_done  in  1  one-cycle pulse when the master finishes a write.
- sccb_nack  in  1  sampled with sccb_done; 1 means the camera NACKed.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished; sticky.
- error  out  1  aborted on retry exhaustion; sticky.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State IDLE.
  - rom_addr=0, sccb_req=0, sccb_reg=0, sccb_val=0, busy=0, done=0, error=0.
  - Retry count 0, delay counter 0.
  - Reset mid-write drops sccb_req the same instant. No partial state survives.
- States: IDLE, FETCH, DECODE, SEND, WAIT_ACK, DELAY, FIN.
- IDLE:
  - start=1 → rom_addr<=0, retry<=0, busy<=1, done<=0, error<=0 → FETCH.
- FETCH: fixed 2 cycles. Covers 1 cycle for rom_addr to reach the ROM plus 1 cycle of ROM register latency. Then → DECODE.
- DECODE: samples rom_data.
  - 16'hFF_FF → FIN.
  - 16'hFF_F0 → load delay counter with DELAY_CYCLES-1 → DELAY.
  - Any other word → sccb_reg<=rom_data[15:8], sccb_val<=rom_data[7:0] → SEND.
- SEND:
  - sccb_req=1. sccb_reg and sccb_val stay stable while sccb_req=1.
  - On a cycle with sccb_req && sccb_ready, the handshake is taken: sccb_req<=0 next cycle → WAIT_ACK.
- WAIT_ACK: waits for sccb_done.
  - sccb_nack=0: retry<=0, advance.
  - sccb_nack=1 and retry<MAX_RETRY-1: retry<=retry+1 → SEND with the same reg/val.
  - sccb_nack=1 and retry=MAX_RETRY-1: error<=1 → FIN.
- DELAY:
  - Counter decrements each cycle. At 0 → advance.
  - Total delay is exactly DELAY_CYCLES cycles in the DELAY state.
- Advance:
  - rom_addr<255: rom_addr<=rom_addr+1 → FETCH.
  - rom_addr=255: → FIN. No wrap to 0.
- FIN: busy<=0, done<=1 → IDLE.
  - done and error stay set until the next accepted start or reset.
- start handling:
  - start while busy=1 is ignored.
  - start in IDLE after completion restarts from address 0 and clears done/error.
- sccb_done is accepted only in WAIT_ACK; in any other state it is ignored.
- Per-entry cost without delay or NACK: 2 (FETCH) + 1 (DECODE) + SEND wait + WAIT_ACK wait.
- Counter width: ceil(log2(DELAY_CYCLES+1)) bits; 32 bits is acceptable.

Test Plan:
- Nominal run. Model ROM {0:12_80, 1:11_80, 2:FF_FF}, SCCB model with ready=1 and done 5 cycles after request.
  - Exactly 2 writes, (12,80) then (11,80).
  - done=1 and busy=0 after the second write; rom_addr stops at 2.
- Delay marker. ROM {0:12_80, 1:FF_F0, 2:04_00, 3:FF_FF}, CLK_FREQ_HZ=1000000, DELAY_MS=1.
  - No SCCB request is issued for entry 1.
  - Exactly 1000 cycles are spent in DELAY.
  - The next request is (04,00).
- Backpressure. Hold sccb_ready=0 for 20 cycles during a request.
  - sccb_req stays 1 with sccb_reg/sccb_val unchanged.
  - Exactly one handshake occurs when ready rises.
- NACK retry. NACK the first 2 attempts of (3A,04), then ACK.
  - 3 requests with identical reg/val; error=0; sequence continues.
- NACK on every attempt of one entry, MAX_RETRY=3.
  - Exactly 3 requests, then error=1, done=1, busy=0.
  - No later ROM entries are written.
- Reset and restart.
  - Assert rst_n=0 during WAIT_ACK: all outputs go to 0 immediately.
  - start pulses during busy are ignored.
  - start after done restarts from rom_addr=0 with done/error cleared.
  - ROM with no FF_FF marker: finishes after address 255, no wrap.

Source files
------------

// File: rtl/ov7670_config_seq.sv
// OV7670 init sequencer: walks the register ROM and issues SCCB writes.
// FF_F0 words insert a timed pause, FF_FF ends the table.
module ov7670_config_seq #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int DELAY_MS    = 10,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_req,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_ready,
    input  logic        sccb_done,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int CW = $clog2(DELAY_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY) + 1;
    localparam logic [CW-1:0] DLY_LOAD = CW'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
    localparam logic [15:0] W_END = 16'hFFFF;
    localparam logic [15:0] W_DLY = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        WAIT_ACK,
        DELAY,
        FIN
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [7:0]     r_addr;
    logic           r_fetch;
    logic [7:0]     r_reg;
    logic [7:0]     r_val;
    logic [RW-1:0]  r_retry;
    logic [CW-1:0]  r_dly;
    logic           r_busy;
    logic           r_done;
    logic           r_error;
    logic           w_last;
    logic           w_retry_ok;
    logic           w_dly_end;

    assign w_last     = (r_addr == 8'hFF);
    assign w_retry_ok = (r_retry < RETRY_LAST);
    assign w_dly_end  = (r_dly == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        sccb_req = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = FETCH;
            end
            FETCH: begin
                if (r_fetch) w_next = DECODE;
            end
            DECODE: begin
                if (rom_data == W_END)      w_next = FIN;
                else if (rom_data == W_DLY) w_next = DELAY;
                else                        w_next = SEND;
            end
            SEND: begin
                sccb_req = 1'b1;
                if (sccb_ready) w_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (sccb_done) begin
                    if (!sccb_nack)      w_next = w_last ? FIN : FETCH;
                    else if (w_retry_ok) w_next = SEND;
                    else                 w_next = FIN;
                end
            end
            DELAY: begin
                if (w_dly_end) w_next = w_last ? FIN : FETCH;
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= 8'd0;
            r_fetch <= 1'b0;
            r_reg   <= 8'd0;
            r_val   <= 8'd0;
            r_retry <= '0;
            r_dly   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= 8'd0;
                        r_fetch <= 1'b0;
                        r_retry <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                // two-cycle toggle: address reaches ROM, then ROM output register
                FETCH: begin
                    r_fetch <= ~r_fetch;
                end
                DECODE: begin
                    if (rom_data == W_DLY) begin
                        r_dly <= DLY_LOAD;
                    end else if (rom_data != W_END) begin
                        r_reg <= rom_data[15:8];
                        r_val <= rom_data[7:0];
                    end
                end
                WAIT_ACK: begin
                    if (sccb_done) begin
                        if (!sccb_nack) begin
                            r_retry <= '0;
                            if (!w_last) r_addr <= r_addr + 8'd1;
                        end else if (w_retry_ok) begin
                            r_retry <= r_retry + 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (w_dly_end) begin
                        if (!w_last) r_addr <= r_addr + 8'd1;
                    end else begin
                        r_dly <= r_dly - 1'b1;
                    end
                end
                FIN: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr = r_addr;
    assign sccb_reg = r_reg;
    assign sccb_val = r_val;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed and randomized checks of the OV7670 init sequencer against
// a table-walk reference model with a registered ROM and an SCCB responder.
module tb_ov7670_config_seq;
    localparam int CLK_HZ = 1000000;
    localparam int DLY_MS = 1;
    localparam int MAXR   = 3;
    localparam int DCYC   = CLK_HZ / 1000 * DLY_MS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_req;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_val;
    logic        sccb_ready;
    logic        sccb_done;
    logic        sccb_nack;
    logic        busy;
    logic        done;
    logic        error;

    logic [15:0] rom [256];
    int          nacks [256];
    logic [15:0] log_q [$];
    logic [15:0] exp_q [$];
    bit          nack_q [$];
    int          done_cyc_q [$];
    int          rise_q [$];
    int          cyc;
    bit          hold_low;
    bit          rand_ready;
    bit          pend;
    bit          pnack;
    bit          prev_req;
    int          pdly;
    int          total;
    int          bad;
    bit          exp_err;
    int          exp_addr;
    int          gap;
    int          len;
    int          nd;
    int          rr;
    bit          ok;
    logic [7:0]  hr;
    logic [7:0]  hv;

    ov7670_config_seq #(
        .CLK_FREQ_HZ (CLK_HZ),
        .DELAY_MS    (DLY_MS),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sccb_req   (sccb_req),
        .sccb_reg   (sccb_reg),
        .sccb_val   (sccb_val),
        .sccb_ready (sccb_ready),
        .sccb_done  (sccb_done),
        .sccb_nack  (sccb_nack),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB responder: acts on falling edges, done pulse 5 cycles after handshake
    initial begin
        cyc = 0;
        pend = 0;
        pnack = 0;
        prev_req = 0;
        pdly = 0;
        sccb_ready = 1'b1;
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (!rst_n) begin
                pend = 0;
                prev_req = 0;
            end else begin
                if (pend) begin
                    if (pdly == 0) begin
                        sccb_done = 1'b1;
                        sccb_nack = pnack;
                        pend = 0;
                        done_cyc_q.push_back(cyc);
                    end else begin
                        pdly--;
                    end
                end
                if (sccb_req && !prev_req) rise_q.push_back(cyc);
                prev_req = sccb_req;
                sccb_ready = !hold_low &&
                    (!rand_ready || $urandom_range(0, 2) != 0);
                if (sccb_req && sccb_ready) begin
                    log_q.push_back({sccb_reg, sccb_val});
                    pend = 1;
                    pdly = 4;
                    pnack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) begin
            rom[a] = 16'hFFFF;
            nacks[a] = 0;
        end
    endtask

    // Walk the table as the camera init would: writes, retries, markers.
    task automatic model();
        exp_q.delete();
        nack_q.delete();
        exp_err = 0;
        exp_addr = 255;
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) begin
                exp_addr = a;
                return;
            end
            if (rom[a] != 16'hFFF0) begin
                for (int t = 0; t < MAXR && t <= nacks[a]; t++) begin
                    exp_q.push_back(rom[a]);
                    nack_q.push_back(t < nacks[a]);
                end
                if (nacks[a] >= MAXR) begin
                    exp_err = 1;
                    exp_addr = a;
                    return;
                end
            end
        end
    endtask

    task automatic start_seq(input string tag);
        model();
        log_q.delete();
        done_cyc_q.delete();
        rise_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_st_busy"}, 32'(busy), 32'd1);
        chk({tag, "_st_done"}, 32'(done), 32'd0);
        chk({tag, "_st_err"}, 32'(error), 32'd0);
        chk({tag, "_st_addr"}, 32'(rom_addr), 32'd0);
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && log_q.size() < n; i++) @(negedge clk);
        chk({tag, "_log_wait"}, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_fin(input string tag, input int budget);
        int n;
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'(exp_err));
        chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        chk({tag, "_nwr"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        total = 0;
        bad = 0;
        hold_low = 0;
        rand_ready = 0;
        rst_n = 1'b0;
        start = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_req", 32'(sccb_req), 32'd0);
        chk("rst_reg", 32'(sccb_reg), 32'd0);
        chk("rst_val", 32'(sccb_val), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // nominal two-write table, with a start pulse while busy
        rom[0] = 16'h1280;
        rom[1] = 16'h1180;
        rom[2] = 16'hFFFF;
        start_seq("nom");
        wait_log("nom", 2, 200);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nom_ign_busy", 32'(busy), 32'd1);
        chk("nom_ign_addr", 32'(rom_addr), 32'd1);
        wait_fin("nom", 300);
        gap = (rise_q.size() > 1 && done_cyc_q.size() > 0) ?
              rise_q[1] - done_cyc_q[0] : -1;
        chk("nom_gap", 32'(gap), 32'd4);

        // delay marker
        clear_rom();
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h0400;
        rom[3] = 16'hFFFF;
        start_seq("dly");
        wait_fin("dly", 3000);
        gap = (rise_q.size() > 1 && done_cyc_q.size() > 0) ?
              rise_q[1] - done_cyc_q[0] : -1;
        chk("dly_gap", 32'(gap), 32'(4 + 3 + DCYC));

        // backpressure
        clear_rom();
        rom[0] = 16'h1280;
        rom[1] = 16'h1181;
        rom[2] = 16'hFFFF;
        hold_low = 1;
        start_seq("bp");
        for (int i = 0; i < 20 && !sccb_req; i++) @(negedge clk);
        chk("bp_req", 32'(sccb_req), 32'd1);
        hr = sccb_reg;
        hv = sccb_val;
        chk("bp_regval", 32'({hr, hv}), 32'(rom[0]));
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (!(sccb_req && sccb_reg == hr && sccb_val == hv)) ok = 0;
        end
        chk("bp_stable", 32'(ok), 32'd1);
        chk("bp_no_hs", 32'(log_q.size()), 32'd0);
        hold_low = 0;
        wait_fin("bp", 300);

        // NACK twice then ACK
        clear_rom();
        rom[0] = 16'h1280;
        rom[1] = 16'h3A04;
        rom[2] = 16'h1100;
        rom[3] = 16'hFFFF;
        nacks[1] = 2;
        start_seq("nk2");
        wait_fin("nk2", 500);

        // NACK on every attempt
        nacks[1] = 3;
        start_seq("nk3");
        wait_fin("nk3", 500);

        // restart after error clears done/error
        nacks[1] = 0;
        start_seq("rst");
        wait_fin("rst", 500);

        // reset during WAIT_ACK
        rom[1] = 16'h1180;
        rom[2] = 16'hFFFF;
        start_seq("ar");
        wait_log("ar", 1, 100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr", 32'(rom_addr), 32'd0);
        chk("ar_req", 32'(sccb_req), 32'd0);
        chk("ar_reg", 32'(sccb_reg), 32'd0);
        chk("ar_val", 32'(sccb_val), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_err", 32'(error), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("ar_post_busy", 32'(busy), 32'd0);
        chk("ar_post_req", 32'(sccb_req), 32'd0);

        // randomized tables, random ready and NACKs
        rand_ready = 1;
        for (int it = 0; it < 5; it++) begin
            clear_rom();
            len = $urandom_range(3, 24);
            nd = 0;
            for (int a = 0; a < len; a++) begin
                if (nd < 2 && $urandom_range(0, 7) == 0) begin
                    rom[a] = 16'hFFF0;
                    nd++;
                end else begin
                    rom[a] = {8'($urandom_range(0, 254)), 8'($urandom)};
                    rr = $urandom_range(0, 19);
                    nacks[a] = (rr < 14) ? 0 :
                               (rr < 19) ? $urandom_range(1, 2) : 3;
                end
            end
            start_seq($sformatf("rnd%0d", it));
            wait_fin($sformatf("rnd%0d", it), 30000);
        end
        rand_ready = 0;

        // no end marker: stops after address 255
        clear_rom();
        for (int a = 0; a < 256; a++)
            rom[a] = {8'($urandom_range(0, 254)), 8'($urandom)};
        start_seq("full");
        wait_fin("full", 10000);
        repeat (20) @(negedge clk);
        chk("full_nowrap_n", 32'(log_q.size()), 32'd256);
        chk("full_nowrap_a", 32'(rom_addr), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
